// File: rtl/instr_collate_mwf.sv
// Collates 32-bit halves of long instructions per wavefront into 64-bit words behind an output FIFO.
// Latency: a pushed entry is visible on out_valid the cycle after the dword is accepted.
// Backpressure: in_ready is registered and drops when the FIFO is full; out_ready pops the head.
module instr_collate_mwf #(
  parameter int NUM_WF     = 40,
  parameter int WFID_W     = 6,
  parameter int PC_W       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [WFID_W-1:0] in_wfid,
  input  logic              in_long,
  input  logic              flush_valid,
  input  logic [WFID_W-1:0] flush_wfid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [WFID_W-1:0] out_wfid,
  output logic              out_long,
  output logic              half_rqd,
  output logic [WFID_W-1:0] half_rqd_wfid,
  output logic [WFID_W:0]   pending_count,
  output logic              err_sticky
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_L  = CNT_W'(FIFO_DEPTH);
  localparam logic [WFID_W:0]  NUM_WF_L = (WFID_W+1)'(NUM_WF);

  // Per-wavefront pending first halves
  logic [NUM_WF-1:0] pending;
  logic [31:0]       pend_dw [NUM_WF];
  logic [PC_W-1:0]   pend_pc [NUM_WF];

  // Output FIFO storage and pointers
  logic [63:0]       fifo_instr [FIFO_DEPTH];
  logic [PC_W-1:0]   fifo_pc    [FIFO_DEPTH];
  logic [WFID_W-1:0] fifo_wfid  [FIFO_DEPTH];
  logic              fifo_long  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;

  logic              in_legal;
  logic              fl_legal;
  logic [WFID_W-1:0] in_idx;
  logic [WFID_W-1:0] fl_idx;
  logic              accept;
  logic              flush_hit;
  logic              take;
  logic              in_pend;
  logic              do_pair;
  logic              do_cap;
  logic              do_short;
  logic              push;
  logic              pop;
  logic              fl_clr;
  logic [63:0]       push_instr;
  logic [PC_W-1:0]   push_pc;

  // Decode the accepted dword into pair / capture / short, with flush to the same slot winning
  always_comb begin
    in_legal   = ({1'b0, in_wfid} < NUM_WF_L);
    fl_legal   = ({1'b0, flush_wfid} < NUM_WF_L);
    in_idx     = in_legal ? in_wfid : '0;
    fl_idx     = fl_legal ? flush_wfid : '0;
    accept     = in_valid & in_ready;
    flush_hit  = flush_valid & (flush_wfid == in_wfid);
    take       = accept & in_legal & ~flush_hit;
    in_pend    = pending[in_idx];
    do_pair    = take & in_pend;
    do_cap     = take & ~in_pend & in_long;
    do_short   = take & ~in_pend & ~in_long;
    push       = do_pair | do_short;
    fl_clr     = flush_valid & fl_legal & pending[fl_idx];
    pop        = out_valid & out_ready;
    push_instr = do_pair ? {in_instr, pend_dw[in_idx]} : {32'b0, in_instr};
    push_pc    = do_pair ? pend_pc[in_idx] : in_pc;
    count_nxt  = count + (push ? CNT_W'(1) : '0) - (pop ? CNT_W'(1) : '0);
  end

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
  assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;
  assign out_wfid  = out_valid ? fifo_wfid[rd_ptr]  : '0;
  assign out_long  = out_valid ? fifo_long[rd_ptr]  : 1'b0;

  // Control state: pending bits, population count, FIFO pointers, ready and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending       <= '0;
      pending_count <= '0;
      err_sticky    <= 1'b0;
      half_rqd      <= 1'b0;
      half_rqd_wfid <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      in_ready      <= 1'b1;
    end else begin
      if (do_cap)  pending[in_idx] <= 1'b1;
      if (do_pair) pending[in_idx] <= 1'b0;
      if (fl_clr)  pending[fl_idx] <= 1'b0;
      pending_count <= pending_count
                     + (do_cap  ? (WFID_W+1)'(1) : '0)
                     - (do_pair ? (WFID_W+1)'(1) : '0)
                     - (fl_clr  ? (WFID_W+1)'(1) : '0);
      if (accept && !in_legal) err_sticky <= 1'b1;
      half_rqd <= do_cap;
      if (do_cap) half_rqd_wfid <= in_wfid;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_nxt;
      in_ready <= (count_nxt != DEPTH_L);
    end
  end

  // Data storage: first-half slots and FIFO entries need no reset
  always_ff @(posedge clk) begin
    if (do_cap) begin
      pend_dw[in_idx] <= in_instr;
      pend_pc[in_idx] <= in_pc;
    end
    if (push) begin
      fifo_instr[wr_ptr] <= push_instr;
      fifo_pc[wr_ptr]    <= push_pc;
      fifo_wfid[wr_ptr]  <= in_wfid;
      fifo_long[wr_ptr]  <= do_pair;
    end
  end

endmodule

// File: tb/tb_instr_collate_mwf.sv
module tb_instr_collate_mwf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [5:0]  in_wfid;
  logic        in_long;
  logic        flush_valid;
  logic [5:0]  flush_wfid;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_instr;
  logic [31:0] out_pc;
  logic [5:0]  out_wfid;
  logic        out_long;
  logic        half_rqd;
  logic [5:0]  half_rqd_wfid;
  logic [6:0]  pending_count;
  logic        err_sticky;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_collate_mwf #(.NUM_WF(40), .WFID_W(6), .PC_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_wfid(in_wfid), .in_long(in_long),
    .flush_valid(flush_valid), .flush_wfid(flush_wfid),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_wfid(out_wfid), .out_long(out_long),
    .half_rqd(half_rqd), .half_rqd_wfid(half_rqd_wfid),
    .pending_count(pending_count), .err_sticky(err_sticky)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are examined 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] w, input logic [31:0] d, input logic [31:0] pc,
                      input logic lng);
    in_valid = 1'b1;
    in_wfid  = w;
    in_instr = d;
    in_pc    = pc;
    in_long  = lng;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_wfid = '0; in_long = 1'b0;
    flush_valid = 1'b0; flush_wfid = '0; out_ready = 1'b1;
    step(); step();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pending_count", pending_count, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_half_rqd", half_rqd, 0);
    chk("rst_out_instr", out_instr, 0);
    rst = 1'b1;
    step();

    // 1. Short instruction
    send(6'd3, 32'hBF81_0000, 32'h100, 1'b0);
    chk("short_valid", out_valid, 1);
    chk("short_instr", out_instr, 64'h0000_0000_BF81_0000);
    chk("short_long", out_long, 0);
    chk("short_pc", out_pc, 32'h100);
    chk("short_wfid", out_wfid, 3);
    step();
    chk("short_drained", out_valid, 0);

    // 2. Interleaved pairs on wf1 and wf2, held in the FIFO
    out_ready = 1'b0;
    send(6'd1, 32'h1111_1111, 32'h10, 1'b1);
    chk("il_half1", half_rqd, 1);
    chk("il_half1_wfid", half_rqd_wfid, 1);
    chk("il_pc1", pending_count, 1);
    chk("il_no_out", out_valid, 0);
    send(6'd2, 32'h2222_2222, 32'h40, 1'b1);
    chk("il_half2", half_rqd, 1);
    chk("il_half2_wfid", half_rqd_wfid, 2);
    chk("il_pc2", pending_count, 2);
    send(6'd1, 32'h3333_3333, 32'h14, 1'b0);
    chk("il_pc3", pending_count, 1);
    chk("il_half_off", half_rqd, 0);
    chk("il_out_valid", out_valid, 1);
    send(6'd2, 32'h4444_4444, 32'h44, 1'b1);
    chk("il_pc4", pending_count, 0);
    chk("il_half_off2", half_rqd, 0);
    out_ready = 1'b1;
    chk("il_first_instr", out_instr, 64'h3333_3333_1111_1111);
    chk("il_first_pc", out_pc, 32'h10);
    chk("il_first_long", out_long, 1);
    chk("il_first_wfid", out_wfid, 1);
    step();
    chk("il_second_instr", out_instr, 64'h4444_4444_2222_2222);
    chk("il_second_pc", out_pc, 32'h40);
    chk("il_second_wfid", out_wfid, 2);
    step();
    chk("il_drained", out_valid, 0);

    // 3. Flush wins against the second half on the same wavefront
    send(6'd5, 32'h5555_5555, 32'h200, 1'b1);
    chk("fl_pend", pending_count, 1);
    flush_valid = 1'b1; flush_wfid = 6'd5;
    send(6'd5, 32'h6666_6666, 32'h204, 1'b0);
    flush_valid = 1'b0;
    chk("fl_pc0", pending_count, 0);
    chk("fl_no_out", out_valid, 0);
    chk("fl_no_half", half_rqd, 0);
    send(6'd5, 32'h7777_7777, 32'h208, 1'b0);
    chk("fl_after_valid", out_valid, 1);
    chk("fl_after_long", out_long, 0);
    chk("fl_after_instr", out_instr, 64'h0000_0000_7777_7777);
    step();
    // Flush of wf6 alongside an unrelated short on wf7
    send(6'd6, 32'hCCCC_CCCC, 32'h300, 1'b1);
    flush_valid = 1'b1; flush_wfid = 6'd6;
    send(6'd7, 32'hDDDD_DDDD, 32'h310, 1'b0);
    flush_valid = 1'b0;
    chk("flx_pc0", pending_count, 0);
    chk("flx_out_instr", out_instr, 64'h0000_0000_DDDD_DDDD);
    chk("flx_out_wfid", out_wfid, 7);
    step();

    // 4. Backpressure with a 4-entry FIFO
    out_ready = 1'b0;
    send(6'd8,  32'hA0, 32'h500, 1'b0);
    send(6'd9,  32'hA1, 32'h504, 1'b0);
    send(6'd10, 32'hA2, 32'h508, 1'b0);
    chk("bp_ready_3", in_ready, 1);
    send(6'd11, 32'hA3, 32'h50C, 1'b0);
    chk("bp_ready_full", in_ready, 0);
    in_valid = 1'b1; in_wfid = 6'd12; in_instr = 32'hA4; in_pc = 32'h510; in_long = 1'b0;
    step();
    chk("bp_held_ready", in_ready, 0);
    chk("bp_held_head", out_instr, 64'hA0);
    out_ready = 1'b1;
    step();
    chk("bp_ready_after_pop", in_ready, 1);
    chk("bp_head_a1", out_instr, 64'hA1);
    step();
    in_valid = 1'b0;
    chk("bp_head_a2", out_instr, 64'hA2);
    step();
    chk("bp_head_a3", out_instr, 64'hA3);
    step();
    chk("bp_head_a4", out_instr, 64'hA4);
    chk("bp_head_a4_pc", out_pc, 32'h510);
    step();
    chk("bp_drained", out_valid, 0);

    // 5. Illegal wavefront id
    send(6'd45, 32'hEEEE_EEEE, 32'h600, 1'b0);
    chk("ill_no_out", out_valid, 0);
    chk("ill_err", err_sticky, 1);
    chk("ill_pc", pending_count, 0);
    step();
    chk("ill_err_sticky", err_sticky, 1);

    // 6. Reset in the middle of a pair, with a queued entry
    out_ready = 1'b0;
    send(6'd4, 32'h4040_4040, 32'h700, 1'b0);
    send(6'd0, 32'h8888_8888, 32'h800, 1'b1);
    chk("mr_pend", pending_count, 1);
    chk("mr_out_before", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("mr_pc0", pending_count, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_err_clear", err_sticky, 0);
    chk("mr_in_ready", in_ready, 1);
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    send(6'd0, 32'h9999_9999, 32'h804, 1'b0);
    chk("mr_short_valid", out_valid, 1);
    chk("mr_short_long", out_long, 0);
    chk("mr_short_instr", out_instr, 64'h0000_0000_9999_9999);
    chk("mr_short_pc", out_pc, 32'h804);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
